// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency memory between the instruction
// fetch requester and the data-access requester of the pipelined core.
// Each granted request is registered and held on the memory port until the
// memory answers (or the access is aborted after TIMEOUT cycles), then the
// owner gets a one-cycle ready pulse with its read data.
//
// Parameters
//   TIMEOUT      maximum cycles spent waiting on the memory (1..255)
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   if_valid_i / if_addr_i       fetch request (held until if_ready_o)
//   if_ready_o / if_rdata_o      fetch completion pulse / data (held between pulses)
//   dm_valid_i / dm_we_i / dm_addr_i / dm_wdata_i / dm_be_i
//                                data request (held until dm_ready_o)
//   dm_ready_o / dm_rdata_o      data completion pulse / data (held between pulses)
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
//                                registered memory request
//   mem_ready_i / mem_rdata_i    memory completion / read data
//   busy_o                       access in progress (REQ or RESP)
//   timeout_o                    sticky abort flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_valid_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ready_o,
    output logic [31:0] if_rdata_o,

    input  logic        dm_valid_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [3:0]  dm_be_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Counter value on the last allowed wait cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        timeout_q, timeout_d;

    // Arbitration candidates. In RESP the owner still holds valid high during
    // its own ready cycle, so its valid is masked to avoid a double grant.
    logic in_resp;
    logic dm_cand;
    logic if_cand;

    assign in_resp = (state_q == S_RESP);
    assign dm_cand = dm_valid_i && !(in_resp && own_q == OWN_DM);
    assign if_cand = if_valid_i && !(in_resp && own_q == OWN_IF);

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                // Data has priority; fetch waits at most one data access.
                if (dm_cand) begin
                    state_d     = S_REQ;
                    own_d       = OWN_DM;
                    cnt_d       = 8'd0;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    mem_be_d    = dm_be_i;
                end else if (if_cand) begin
                    state_d     = S_REQ;
                    own_d       = OWN_IF;
                    cnt_d       = 8'd0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = 32'h0;
                    mem_be_d    = 4'hF;
                end else begin
                    state_d     = S_IDLE;
                end
            end

            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // A completion on the final wait cycle still wins over abort.
                if (mem_ready_i) begin
                    state_d = S_RESP;
                    if (own_q == OWN_DM) dm_rdata_d = mem_rdata_i;
                    else                 if_rdata_d = mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_RESP;
                    timeout_d = 1'b1;
                    if (own_q == OWN_DM) dm_rdata_d = 32'h0;
                    else                 if_rdata_d = 32'h0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            own_q       <= OWN_IF;
            cnt_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state, so mem_req_o and the ready
    // pulses drop together with the asynchronous reset.
    // ------------------------------------------------------------------------
    assign mem_req_o   = (state_q == S_REQ);
    assign busy_o      = (state_q != S_IDLE);
    assign if_ready_o  = in_resp && (own_q == OWN_IF);
    assign dm_ready_o  = in_resp && (own_q == OWN_DM);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by a randomized phase. The reference model is
// transaction level: each grant predicts its pulse cycle from the memory
// latency (capped by TIMEOUT), the data from a word-array memory, and the
// owner from the data-first / mask-the-owner rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_ready_o;
    logic [31:0] if_rdata_o;
    logic        dm_valid_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [3:0]  dm_be_i = '0;
    logic        dm_ready_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;
    logic        timeout_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_valid_i(if_valid_i), .if_addr_i(if_addr_i),
        .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
        .dm_valid_i(dm_valid_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
        .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    // Requester intent (applied to the ports inside body()).
    logic        if_v = 0;
    logic [31:0] if_a = 0;
    int          if_left = 0;
    logic        dm_v = 0, dm_w = 0;
    logic [31:0] dm_a = 0, dm_wd = 0;
    logic [3:0]  dm_b = 0;
    int          dm_left = 0;
    bit          rnd_mode = 0;
    int          lat_force = 0;
    bit          gap_on = 0;
    int          last_if = -1;

    // Model of the access in flight.
    bit          m_busy = 0, m_own = 0, m_abort = 0, m_to = 0;
    int          m_start = 0, m_end = 0, n = 0;
    logic [31:0] m_addr = 0, m_wd = 0, m_data = 0;
    logic        m_we = 0;
    logic [3:0]  m_be = 0;
    logic [31:0] e_if_rd = 0, e_dm_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic grant(input bit own);
        int lat;
        if (lat_force >= 0) lat = lat_force;
        else if ($urandom_range(0, 7) == 0) lat = 9;
        else lat = $urandom_range(0, 3);
        m_busy  = 1;
        m_own   = own;
        m_start = n + 1;
        m_abort = (lat >= TO);
        m_end   = m_start + (m_abort ? TO - 1 : lat) + 1;
        if (own) begin
            m_addr = dm_a; m_we = dm_w; m_wd = dm_wd; m_be = dm_b;
        end else begin
            m_addr = if_a; m_we = 0; m_wd = 0; m_be = 4'hF;
        end
        if (m_abort)   m_data = 32'h0;
        else if (m_we) m_data = $urandom();
        else           m_data = mem[m_addr[9:2]];
    endtask

    // One cycle, evaluated at the falling edge.
    task automatic body();
        bit pulse, in_req;
        pulse  = m_busy && (n == m_end);
        in_req = m_busy && (n < m_end);
        if (pulse) begin
            if (m_abort) m_to = 1;
            if (m_own) e_dm_rd = m_data; else e_if_rd = m_data;
            if (!m_abort && m_we)
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] = m_wd[8*b +: 8];
        end

        chk("mem_req",  32'(mem_req_o),  32'(in_req));
        chk("busy",     32'(busy_o),     32'(m_busy));
        chk("if_ready", 32'(if_ready_o), 32'(pulse && !m_own));
        chk("dm_ready", 32'(dm_ready_o), 32'(pulse && m_own));
        chk("if_rdata", if_rdata_o, e_if_rd);
        chk("dm_rdata", dm_rdata_o, e_dm_rd);
        chk("timeout",  32'(timeout_o),  32'(m_to));
        if (in_req) begin
            chk("mem_addr",  mem_addr_o, m_addr);
            chk("mem_we",    32'(mem_we_o), 32'(m_we));
            chk("mem_wdata", mem_wdata_o, m_wd);
            chk("mem_be",    32'(mem_be_o), 32'(m_be));
        end
        if (gap_on && if_ready_o) begin
            if (last_if >= 0) chk("if_gap", n - last_if, 3);
            last_if = n;
        end

        // Memory: answers on its chosen wait cycle; outside REQ it toggles
        // mem_ready_i randomly, which must have no effect.
        if (in_req) begin
            mem_ready_i = !m_abort && (n == m_end - 1);
            mem_rdata_i = mem_ready_i ? m_data : $urandom();
        end else begin
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom();
        end

        if (pulse && !m_own) begin
            if_left--;
            if (if_left > 0) if_a = if_a + 4; else if_v = 0;
        end
        if (pulse && m_own) begin
            dm_left--;
            if (dm_left > 0) dm_a = dm_a + 4; else dm_v = 0;
        end
        if (rnd_mode) begin
            if (!if_v && $urandom_range(0, 3) == 0) begin
                if_v = 1; if_a = $urandom(); if_left = 1;
            end
            if (!dm_v && $urandom_range(0, 3) == 0) begin
                dm_v = 1; dm_w = 1'($urandom_range(0, 1)); dm_a = $urandom();
                dm_wd = $urandom(); dm_b = 4'($urandom()); dm_left = 1;
            end
        end
        if_valid_i = if_v; if_addr_i = if_a;
        dm_valid_i = dm_v; dm_we_i = dm_w; dm_addr_i = dm_a;
        dm_wdata_i = dm_wd; dm_be_i = dm_b;

        if (!m_busy || pulse) begin
            if (dm_v && !(pulse && m_own))      grant(1);
            else if (if_v && !(pulse && !m_own)) grant(0);
            else                                 m_busy = 0;
        end
        n++;
    endtask

    task automatic run(input int k);
        repeat (k) begin
            @(negedge clk_i);
            body();
        end
    endtask

    // Reset asserted shortly after a rising edge; all outputs must clear at once.
    task automatic do_reset();
        @(posedge clk_i);
        #2 rst_i = 0;
        #1;
        chk("rst_mem_req",  32'(mem_req_o), 0);
        chk("rst_busy",     32'(busy_o), 0);
        chk("rst_if_ready", 32'(if_ready_o), 0);
        chk("rst_dm_ready", 32'(dm_ready_o), 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be",   32'(mem_be_o), 0);
        chk("rst_mem_we",   32'(mem_we_o), 0);
        chk("rst_timeout",  32'(timeout_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1;
        m_busy = 0; m_to = 0; e_if_rd = 0; e_dm_rd = 0;
        body();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        do_reset();
        run(2);

        // Single zero-wait fetch.
        mem[8'h10] = 32'h00A00093;
        lat_force = 0;
        if_v = 1; if_a = 32'h40; if_left = 1;
        run(5);
        chk("t1_if_rdata", if_rdata_o, 32'h00A00093);

        // Simultaneous requests: data write first, then fetch.
        if_v = 1; if_a = 32'h44; if_left = 1;
        dm_v = 1; dm_w = 1; dm_a = 32'h100; dm_wd = 32'h12345678; dm_b = 4'b0011; dm_left = 1;
        run(8);

        // Data read with three wait cycles.
        mem[8'h80] = 32'hCAFEF00D;
        lat_force = 3;
        dm_v = 1; dm_w = 0; dm_a = 32'h200; dm_b = 4'hF; dm_left = 1;
        run(8);
        chk("t3_dm_rdata", dm_rdata_o, 32'hCAFEF00D);

        // Fetch that is never answered, then one that is.
        lat_force = 99;
        if_v = 1; if_a = 32'h80; if_left = 1;
        run(8);
        chk("t4_timeout", 32'(timeout_o), 1);
        chk("t4_if_rdata", if_rdata_o, 0);
        lat_force = 1;
        if_v = 1; if_a = 32'h84; if_left = 1;
        run(6);
        chk("t4_if_rdata2", if_rdata_o, mem[8'h21]);
        chk("t4_timeout_sticky", 32'(timeout_o), 1);

        // Reset in the second wait cycle; the held fetch is re-granted.
        lat_force = 5;
        if_v = 1; if_a = 32'h88; if_left = 1;
        run(2);
        lat_force = 1;
        do_reset();
        run(6);
        chk("t5_if_rdata", if_rdata_o, mem[8'h22]);

        // Fetch held for three back-to-back accesses.
        lat_force = 0;
        if_v = 1; if_a = 32'h100; if_left = 3;
        gap_on = 1; last_if = -1;
        run(12);
        gap_on = 0;

        // Randomized traffic and latencies.
        rnd_mode = 1;
        lat_force = -1;
        run(3000);
        rnd_mode = 0;
        if_v = 0; dm_v = 0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
